channel_buffer_bank: RTL and testbench
======================================

CHANNEL_BUFFER_BANK -- requirements
Module: channel_buffer_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: word width in bits.
REQ-002 SHALL have parameter NUM_CH, default 4: number of independent channels, 1..16.
REQ-003 SHALL have parameter DEPTH, default 1024: words per channel, a power of two.
REQ-004 SHALL have parameter ADDR_WIDTH, default 10: log2(DEPTH).
REQ-005 SHALL have parameter CH_WIDTH, default 2: channel-select width, max(1, ceil(log2(NUM_CH))).
REQ-006 SHALL have the port list below, clock and reset first.
- CHANNEL_BUFFER_BANK_Clk  in  1  clock; all state on rising edge.
- CHANNEL_BUFFER_BANK_Reset_n  in  1  asynchronous active-low reset.
- CHANNEL_BUFFER_BANK_We  in  1  write request.
- CHANNEL_BUFFER_BANK_Wr_Ch  in  CH_WIDTH  write channel select.
- CHANNEL_BUFFER_BANK_Data_In  in  DATA_WIDTH  write data.
- CHANNEL_BUFFER_BANK_Oe  in  1  read request.
- CHANNEL_BUFFER_BANK_Rd_Ch  in  CH_WIDTH  read channel select.
- CHANNEL_BUFFER_BANK_Wptclr  in  NUM_CH  per-channel write-pointer clear, active high.
- CHANNEL_BUFFER_BANK_Rptclr  in  NUM_CH  per-channel read-pointer rewind, active high.
- CHANNEL_BUFFER_BANK_Data_Out  out  DATA_WIDTH  registered read data.
- CHANNEL_BUFFER_BANK_Valid  out  1  Data_Out holds a word read in the previous cycle.
- CHANNEL_BUFFER_BANK_Full  out  NUM_CH  per-channel full flag.
- CHANNEL_BUFFER_BANK_Empty  out  NUM_CH  per-channel nothing-left-to-read flag.
- CHANNEL_BUFFER_BANK_Err  out  2  sticky {underflow, overflow}.

Function
REQ-007 SHALL keep, per channel, a write pointer Wp and a read pointer Rp, each ADDR_WIDTH+1 bits.
REQ-008 Full[c] SHALL be 1 iff Wp[c]==DEPTH; Empty[c] SHALL be 1 iff Rp[c]==Wp[c]; both combinational from the pointers.
REQ-009 A write SHALL be accepted iff We=1, Wr_Ch<NUM_CH, Full[Wr_Ch]=0, and Wptclr[Wr_Ch]=0; it stores Data_In at channel Wr_Ch, word Wp, then increments Wp by 1.
REQ-010 A read SHALL be accepted iff Oe=1, Rd_Ch<NUM_CH, Empty[Rd_Ch]=0, and Rptclr[Rd_Ch]=0; it increments Rp by 1.
REQ-011 Read latency SHALL be 1 cycle: on the edge after an accepted read, Data_Out=word and Valid=1; otherwise Data_Out=0 and Valid=0.
REQ-012 Reads SHALL NOT free space: data persists until Wptclr, allowing rewind and re-read (kernel reuse).
REQ-013 Wptclr[c]=1 SHALL set Wp[c]=0 and Rp[c]=0 on the next edge and block a write to c that cycle.
REQ-014 Rptclr[c]=1 SHALL set Rp[c]=0 on the next edge and block a read of c that cycle; Wp and contents SHALL be unchanged.
REQ-015 A same-cycle write and read on the same channel with Empty=1 SHALL leave the read rejected (no bypass); the word becomes readable on the next cycle.
REQ-016 Same-cycle write and read on different channels SHALL both proceed independently.
REQ-017 A rejected request SHALL change no pointer and no memory word.
REQ-018 Pointers SHALL NOT wrap; Wp saturates at DEPTH through the Full gating.

Reset
REQ-019 Reset_n=0 SHALL asynchronously clear all Wp and Rp, Data_Out, Valid, and Err, giving Full=0 and Empty=all ones.
REQ-020 Memory contents SHALL NOT be reset; assertion mid-operation SHALL abort any in-flight read (Valid=0).

Configuration
REQ-021 With CHANNEL_BUFFER_BANK_ERR_EN defined: Err[0] SHALL set on We=1 to a full channel, and Err[1] SHALL set on Oe=1 to an empty channel; both stay set until reset, and an out-of-range channel also sets the matching bit.
REQ-022 Without CHANNEL_BUFFER_BANK_ERR_EN: Err SHALL be constant 0; the port list SHALL be unchanged.

Verification
REQ-023 Reset, then write 0x0011,0x0022 to ch1 -> Wp[1]=2 and Empty[1]=0; read ch1 twice -> Data_Out 0x0011 then 0x0022 with Valid=1, each 1 cycle after Oe, and Empty[1]=1 after.
REQ-024 Fill ch0 with DEPTH words -> Full[0]=1; one more write -> memory unchanged, and Err[0]=1 with ERR_EN.
REQ-025 After REQ-023, pulse Rptclr[1] then read -> 0x0011 again.
REQ-026 Simultaneous write ch2=0xABCD and read ch2 while Empty -> Valid=0; next-cycle read -> 0xABCD.
REQ-027 Assert Reset_n mid-stream with Valid=1 -> Valid=0, Data_Out=0 immediately, and Empty=all ones.
REQ-028 Wptclr[3] with We to ch3 in the same cycle -> Wp[3]=0 and no word stored.

Source files
------------

// File: rtl/channel_buffer_bank.sv
// Multi-channel linear word buffer with independent write/read pointers and rewind.
// Optional sticky error flags are built when CHANNEL_BUFFER_BANK_ERR_EN is defined.
module channel_buffer_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int CH_WIDTH   = 2
) (
  input  logic                  CHANNEL_BUFFER_BANK_Clk,
  input  logic                  CHANNEL_BUFFER_BANK_Reset_n,
  input  logic                  CHANNEL_BUFFER_BANK_We,
  input  logic [CH_WIDTH-1:0]   CHANNEL_BUFFER_BANK_Wr_Ch,
  input  logic [DATA_WIDTH-1:0] CHANNEL_BUFFER_BANK_Data_In,
  input  logic                  CHANNEL_BUFFER_BANK_Oe,
  input  logic [CH_WIDTH-1:0]   CHANNEL_BUFFER_BANK_Rd_Ch,
  input  logic [NUM_CH-1:0]     CHANNEL_BUFFER_BANK_Wptclr,
  input  logic [NUM_CH-1:0]     CHANNEL_BUFFER_BANK_Rptclr,
  output logic [DATA_WIDTH-1:0] CHANNEL_BUFFER_BANK_Data_Out,
  output logic                  CHANNEL_BUFFER_BANK_Valid,
  output logic [NUM_CH-1:0]     CHANNEL_BUFFER_BANK_Full,
  output logic [NUM_CH-1:0]     CHANNEL_BUFFER_BANK_Empty,
  output logic [1:0]            CHANNEL_BUFFER_BANK_Err
);

  localparam int MEM_WORDS = NUM_CH * DEPTH;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [ADDR_WIDTH:0]   wp  [NUM_CH];
  logic [ADDR_WIDTH:0]   rp  [NUM_CH];

  logic [NUM_CH-1:0]     full, empty;
  logic [NUM_CH-1:0]     wr_sel, rd_sel, wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic                  wr_any, rd_any;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;

  // Out-of-range channel selects match no channel, so they are never accepted.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign full[c]   = (wp[c] == (ADDR_WIDTH+1)'(DEPTH));
    assign empty[c]  = (rp[c] == wp[c]);
    assign wr_sel[c] = CHANNEL_BUFFER_BANK_We && (CHANNEL_BUFFER_BANK_Wr_Ch == CH_WIDTH'(c));
    assign rd_sel[c] = CHANNEL_BUFFER_BANK_Oe && (CHANNEL_BUFFER_BANK_Rd_Ch == CH_WIDTH'(c));
    assign wr_acc[c] = wr_sel[c] && !full[c] && !CHANNEL_BUFFER_BANK_Wptclr[c];
    assign rd_acc[c] = rd_sel[c] && !empty[c] && !CHANNEL_BUFFER_BANK_Rptclr[c];

    always_ff @(posedge CHANNEL_BUFFER_BANK_Clk or negedge CHANNEL_BUFFER_BANK_Reset_n) begin
      if (!CHANNEL_BUFFER_BANK_Reset_n) begin
        wp[c] <= '0;
        rp[c] <= '0;
      end else if (CHANNEL_BUFFER_BANK_Wptclr[c]) begin
        wp[c] <= '0;
        rp[c] <= '0;
      end else begin
        if (wr_acc[c]) wp[c] <= wp[c] + 1'b1;
        if (CHANNEL_BUFFER_BANK_Rptclr[c]) rp[c] <= '0;
        else if (rd_acc[c]) rp[c] <= rp[c] + 1'b1;
      end
    end
  end

  assign wr_any = |wr_acc;
  assign rd_any = |rd_acc;

  always_comb begin
    wr_addr = '0;
    rd_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_acc[c]) wr_addr = wp[c][ADDR_WIDTH-1:0];
      if (rd_acc[c]) rd_addr = rp[c][ADDR_WIDTH-1:0];
    end
  end

  // Storage is deliberately not reset so a rewind after reset-free operation can re-read it.
  always_ff @(posedge CHANNEL_BUFFER_BANK_Clk) begin
    if (wr_any) mem[{CHANNEL_BUFFER_BANK_Wr_Ch, wr_addr}] <= CHANNEL_BUFFER_BANK_Data_In;
  end

  always_ff @(posedge CHANNEL_BUFFER_BANK_Clk or negedge CHANNEL_BUFFER_BANK_Reset_n) begin
    if (!CHANNEL_BUFFER_BANK_Reset_n) begin
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      valid    <= rd_any;
      data_out <= rd_any ? mem[{CHANNEL_BUFFER_BANK_Rd_Ch, rd_addr}] : '0;
    end
  end

`ifdef CHANNEL_BUFFER_BANK_ERR_EN
  logic [1:0] err;
  logic       overflow, underflow;

  // A request matching no non-full (non-empty) channel is full (empty) or out of range.
  assign overflow  = CHANNEL_BUFFER_BANK_We && !(|(wr_sel & ~full));
  assign underflow = CHANNEL_BUFFER_BANK_Oe && !(|(rd_sel & ~empty));

  always_ff @(posedge CHANNEL_BUFFER_BANK_Clk or negedge CHANNEL_BUFFER_BANK_Reset_n) begin
    if (!CHANNEL_BUFFER_BANK_Reset_n) err <= 2'b00;
    else err <= err | {underflow, overflow};
  end

  assign CHANNEL_BUFFER_BANK_Err = err;
`else
  assign CHANNEL_BUFFER_BANK_Err = 2'b00;
`endif

  assign CHANNEL_BUFFER_BANK_Data_Out = data_out;
  assign CHANNEL_BUFFER_BANK_Valid    = valid;
  assign CHANNEL_BUFFER_BANK_Full     = full;
  assign CHANNEL_BUFFER_BANK_Empty    = empty;

endmodule

// File: tb/tb_channel_buffer_bank.sv
// Directed plus randomized bench for channel_buffer_bank against a per-channel array model.
module tb_channel_buffer_bank;
  localparam int DW = 16, NCH = 4, DEPTH = 1024, AW = 10, CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0, oe = 1'b0;
  logic [CW-1:0] wr_ch = '0, rd_ch = '0;
  logic [DW-1:0] din = '0;
  logic [NCH-1:0] wclr = '0, rclr = '0;
  logic [DW-1:0] dout;
  logic          valid;
  logic [NCH-1:0] full, empty;
  logic [1:0]    err;

  int tests = 0, fails = 0;

  // Reference state: plain integer pointers and a 2-D word array.
  int            wp_m [NCH];
  int            rp_m [NCH];
  logic [DW-1:0] mem_m [NCH][DEPTH];
  logic [DW-1:0] exp_dout;
  logic          exp_valid;
  logic [1:0]    err_m;

  channel_buffer_bank #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEPTH),
                        .ADDR_WIDTH(AW), .CH_WIDTH(CW)) dut (
    .CHANNEL_BUFFER_BANK_Clk(clk),
    .CHANNEL_BUFFER_BANK_Reset_n(rst_n),
    .CHANNEL_BUFFER_BANK_We(we),
    .CHANNEL_BUFFER_BANK_Wr_Ch(wr_ch),
    .CHANNEL_BUFFER_BANK_Data_In(din),
    .CHANNEL_BUFFER_BANK_Oe(oe),
    .CHANNEL_BUFFER_BANK_Rd_Ch(rd_ch),
    .CHANNEL_BUFFER_BANK_Wptclr(wclr),
    .CHANNEL_BUFFER_BANK_Rptclr(rclr),
    .CHANNEL_BUFFER_BANK_Data_Out(dout),
    .CHANNEL_BUFFER_BANK_Valid(valid),
    .CHANNEL_BUFFER_BANK_Full(full),
    .CHANNEL_BUFFER_BANK_Empty(empty),
    .CHANNEL_BUFFER_BANK_Err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [NCH-1:0] full_m();
    for (int c = 0; c < NCH; c++) full_m[c] = (wp_m[c] == DEPTH);
  endfunction

  function automatic logic [NCH-1:0] empty_m();
    for (int c = 0; c < NCH; c++) empty_m[c] = (rp_m[c] == wp_m[c]);
  endfunction

  function automatic logic [1:0] err_exp();
`ifdef CHANNEL_BUFFER_BANK_ERR_EN
    return err_m;
`else
    return 2'b00;
`endif
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      wp_m[c] = 0;
      rp_m[c] = 0;
    end
    exp_dout = '0;
    exp_valid = 1'b0;
    err_m = 2'b00;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"},  32'(dout),  32'(exp_dout));
    chk({tag, ".valid"}, 32'(valid), 32'(exp_valid));
    chk({tag, ".full"},  32'(full),  32'(full_m()));
    chk({tag, ".empty"}, 32'(empty), 32'(empty_m()));
    chk({tag, ".err"},   32'(err),   32'(err_exp()));
  endtask

  // One clock: drive, update the model from the rules, clock, then compare.
  task automatic cycle(input string tag, input logic w, input int wc, input logic [DW-1:0] d,
                       input logic r, input int rc,
                       input logic [NCH-1:0] wcl, input logic [NCH-1:0] rcl);
    bit wr_ok, rd_ok;
    we = w; wr_ch = CW'(wc); din = d; oe = r; rd_ch = CW'(rc); wclr = wcl; rclr = rcl;
    wr_ok = w && wc < NCH && wp_m[wc] != DEPTH && !wcl[wc];
    rd_ok = r && rc < NCH && rp_m[rc] != wp_m[rc] && !rcl[rc];
    if (w && (wc >= NCH || wp_m[wc] == DEPTH)) err_m[0] = 1'b1;
    if (r && (rc >= NCH || rp_m[rc] == wp_m[rc])) err_m[1] = 1'b1;
    exp_valid = rd_ok;
    exp_dout  = rd_ok ? mem_m[rc][rp_m[rc]] : '0;
    if (wr_ok) begin
      mem_m[wc][wp_m[wc]] = d;
      wp_m[wc]++;
    end
    if (rd_ok) rp_m[rc]++;
    for (int c = 0; c < NCH; c++) begin
      if (rcl[c]) rp_m[c] = 0;
      if (wcl[c]) begin
        wp_m[c] = 0;
        rp_m[c] = 0;
      end
    end
    @(posedge clk);
    #1;
    we = 1'b0; oe = 1'b0; wclr = '0; rclr = '0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two words into ch1, read back in order.
    cycle("wr1a", 1, 1, 16'h0011, 0, 0, '0, '0);
    cycle("wr1b", 1, 1, 16'h0022, 0, 0, '0, '0);
    cycle("rd1a", 0, 0, '0, 1, 1, '0, '0);
    cycle("rd1b", 0, 0, '0, 1, 1, '0, '0);
    cycle("idle1", 0, 0, '0, 0, 0, '0, '0);
    cycle("rd1_empty", 0, 0, '0, 1, 1, '0, '0);

    // Rewind ch1 and re-read the first word.
    cycle("rclr1", 0, 0, '0, 0, 0, '0, 4'b0010);
    cycle("rd1_again", 0, 0, '0, 1, 1, '0, '0);

    // Rewind request blocks a same-cycle read.
    cycle("rclr1_rd", 0, 0, '0, 1, 1, '0, 4'b0010);

    // Same-cycle write and read on an empty ch2: no bypass.
    cycle("wr_rd2", 1, 2, 16'hABCD, 1, 2, '0, '0);
    cycle("rd2", 0, 0, '0, 1, 2, '0, '0);

    // Different channels in the same cycle both proceed.
    cycle("wr3_rd1", 1, 3, 16'h3333, 1, 1, '0, '0);

    // Write-pointer clear on ch3 with a concurrent write to ch3.
    cycle("wclr3_wr", 1, 3, 16'h7777, 0, 0, 4'b1000, '0);
    cycle("rd3_after_clr", 0, 0, '0, 1, 3, '0, '0);

    // Fill ch0 to DEPTH, then overflow.
    for (int i = 0; i < DEPTH; i++)
      cycle("fill0", 1, 0, DW'($urandom), 0, 0, '0, '0);
    cycle("ovf0", 1, 0, 16'hDEAD, 0, 0, '0, '0);
    cycle("rd0_w0", 0, 0, '0, 1, 0, '0, '0);
    cycle("rd0_w1", 0, 0, '0, 1, 0, '0, '0);

    // Randomized traffic; clears are kept rare so channels accumulate data.
    for (int i = 0; i < 400; i++) begin
      logic [NCH-1:0] wc, rc;
      wc = ($urandom_range(0, 31) == 0) ? NCH'($urandom) : '0;
      rc = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
      cycle("rand", 1'($urandom), $urandom_range(0, NCH-1), DW'($urandom),
            1'($urandom), $urandom_range(0, NCH-1), wc, rc);
    end

    // Mid-stream asynchronous reset while Valid is high.
    cycle("pre_rst_wr", 1, 2, 16'h5A5A, 0, 0, '0, '0);
    cycle("pre_rst_rd", 0, 0, '0, 1, 2, '0, '0);
    chk("pre_rst_valid", 32'(valid), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("post_rst_rd", 0, 0, '0, 1, 2, '0, '0);
    cycle("post_rst_wr", 1, 2, 16'h1234, 0, 0, '0, '0);
    cycle("post_rst_rd2", 0, 0, '0, 1, 2, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
